// File: rtl/checkbits_monitor.sv
// Self-test checkbits monitor: synchronise, debounce and decode start/checkpoint/pass/fail codes
// with a programmable watchdog. Optional feature macro: CHKMON_CHECKPOINT_EN (checkpoint counting + watchdog reload).
module checkbits_monitor #(
  parameter int unsigned           WIDTH     = 16,
  parameter int unsigned           PREFIX_W  = 12,
  parameter logic [PREFIX_W-1:0]   PREFIX    = 12'hAB6,
  parameter int unsigned           TIMEOUT_W = 32,
  parameter int unsigned           STABLE    = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [WIDTH-1:0]              checkbits_i,
  input  logic [TIMEOUT_W-1:0]          timeout_i,
  input  logic                          clear_i,
  output logic [2:0]                    state_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic                          timeout_o,
  output logic [WIDTH-PREFIX_W-1:0]     last_code_o,
  output logic [TIMEOUT_W-1:0]          cycles_o,
  output logic [7:0]                    checkpoint_cnt_o
);

  localparam int unsigned LOW_W = WIDTH - PREFIX_W;
  localparam int unsigned CNT_W = $clog2(STABLE + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  logic [WIDTH-1:0]     sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [WIDTH-1:0]     acc_word_q, acc_word_d;
  logic                 acc_valid_q, acc_valid_d;
  logic [CNT_W-1:0]     stab_cnt_q, stab_cnt_d;
  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cycles_q, cycles_d;
  logic [7:0]           ckpt_q, ckpt_d;
  logic [LOW_W-1:0]     last_q, last_d;

  logic [CNT_W-1:0]     run_len;
  logic                 accept;
  logic [LOW_W-1:0]     low;
  logic                 is_start, is_pass, is_fail;
  logic                 wd_expire;
  logic [TIMEOUT_W-1:0] cycles_inc;

  // Input path: run_len counts how many consecutive cycles the synchronised word has held,
  // including the current one, saturating at STABLE.
  always_comb begin
    sync1_d = checkbits_i;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    if (sync2_q == hist_q) begin
      run_len = (stab_cnt_q >= CNT_W'(STABLE)) ? stab_cnt_q : stab_cnt_q + CNT_W'(1);
    end else begin
      run_len = CNT_W'(1);
    end
    accept = (run_len >= CNT_W'(STABLE)) &&
             (sync2_q[WIDTH-1 -: PREFIX_W] == PREFIX) &&
             (!acc_valid_q || (sync2_q != acc_word_q)) &&
             !clear_i;
    stab_cnt_d  = clear_i ? '0 : run_len;
    acc_word_d  = accept ? sync2_q : acc_word_q;
    acc_valid_d = clear_i ? 1'b0 : (accept | acc_valid_q);
    low         = sync2_q[LOW_W-1:0];
    is_start    = (low == LOW_W'(0));
    is_pass     = (low == LOW_W'(1));
    is_fail     = (low == LOW_W'(2));
  end

  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    ckpt_d     = ckpt_q;
    last_d     = last_q;
    wd_expire  = (timeout_i != '0) && (cycles_q == timeout_i - TIMEOUT_W'(1));
    cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + TIMEOUT_W'(1);
    if (clear_i) begin
      state_d  = S_IDLE;
      cycles_d = '0;
      ckpt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            last_d = low;
            if (is_start) begin
              state_d  = S_RUN;
              cycles_d = '0;
              ckpt_d   = '0;
            end
          end
        end
        S_RUN: begin
          cycles_d = cycles_inc;
          if (wd_expire) state_d = S_TIMEOUT;
          // Accepted codes are evaluated after the watchdog so they win the same-edge race.
          if (accept) begin
            last_d = low;
            if (is_start) begin
              state_d  = S_RUN;
              cycles_d = '0;
              ckpt_d   = '0;
            end else if (is_pass) begin
              state_d = S_PASS;
            end else if (is_fail) begin
              state_d = S_FAIL;
            end else begin
`ifdef CHKMON_CHECKPOINT_EN
              state_d  = S_RUN;
              cycles_d = '0;
              ckpt_d   = (ckpt_q == 8'hFF) ? ckpt_q : ckpt_q + 8'd1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= '0;
      acc_word_q  <= '0;
      acc_valid_q <= 1'b0;
      stab_cnt_q  <= '0;
      state_q     <= S_IDLE;
      cycles_q    <= '0;
      ckpt_q      <= '0;
      last_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      acc_word_q  <= acc_word_d;
      acc_valid_q <= acc_valid_d;
      stab_cnt_q  <= stab_cnt_d;
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      ckpt_q      <= ckpt_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_o          = state_q;
    pass_o           = (state_q == S_PASS);
    fail_o           = (state_q == S_FAIL);
    timeout_o        = (state_q == S_TIMEOUT);
    done_o           = pass_o | fail_o | timeout_o;
    last_code_o      = last_q;
    cycles_o         = cycles_q;
    checkpoint_cnt_o = ckpt_q;
  end

endmodule
